// File: rtl/alu_op_sequencer.sv
// ALU initiator: accepts one op per request handshake, pulses CE for one cycle, captures RES/flags after LAT or MUL_LAT edges.
// Latency: accept -> ISSUE (1) -> WAIT (N edges after the issue edge) -> RESP; one op outstanding at a time.
// Backpressure: REQ_READY low outside IDLE; RESP holds RSP_RES/RSP_FLAGS until RSP_READY. Optional stats via ALU_OP_SEQUENCER_STATS_EN.
module alu_op_sequencer #(
    parameter int WIDTH   = 8,
    parameter int CMD_W   = 4,
    parameter int LAT     = 1,
    parameter int MUL_LAT = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ_VALID,
    output logic               REQ_READY,
    input  logic [WIDTH-1:0]   REQ_OPA,
    input  logic [WIDTH-1:0]   REQ_OPB,
    input  logic [CMD_W-1:0]   REQ_CMD,
    input  logic               REQ_MODE,
    input  logic               REQ_CIN,
    input  logic [1:0]         REQ_INP_VALID,
    output logic               RSP_VALID,
    input  logic               RSP_READY,
    output logic [2*WIDTH-1:0] RSP_RES,
    output logic [5:0]         RSP_FLAGS,
    output logic [1:0]         INP_VALID,
    output logic               MODE,
    output logic [CMD_W-1:0]   CMD,
    output logic               CE,
    output logic [WIDTH-1:0]   OPA,
    output logic [WIDTH-1:0]   OPB,
    output logic               CIN,
    input  logic [2*WIDTH-1:0] RES,
    input  logic               ERR,
    input  logic               OFLOW,
    input  logic               COUT,
    input  logic               G,
    input  logic               L,
    input  logic               E
`ifdef ALU_OP_SEQUENCER_STATS_EN
    ,
    output logic [15:0]        ISSUE_CNT,
    output logic [15:0]        ERR_CNT
`endif
);

    localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               req_rdy_q, req_rdy_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               mode_q, mode_d;
    logic               cin_q, cin_d;
    logic [1:0]         inp_valid_q, inp_valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic [5:0]         rsp_flags_q, rsp_flags_d;

    logic accept;
    logic capture;
    logic is_mul;

    assign accept  = (state_q == S_IDLE) && REQ_VALID && req_rdy_q;
    assign capture = (state_q == S_WAIT) && (cnt_q == '0);
    assign is_mul  = REQ_MODE && ((REQ_CMD == CMD_W'(9)) || (REQ_CMD == CMD_W'(10)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)         state_d = S_ISSUE;
            S_ISSUE:                     state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0)    state_d = S_RESP;
            S_RESP:  if (RSP_READY)      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        CE        = (state_q == S_ISSUE);
        INP_VALID = (state_q == S_ISSUE) ? inp_valid_q : 2'b00;
        OPA       = opa_q;
        OPB       = opb_q;
        CMD       = cmd_q;
        MODE      = mode_q;
        CIN       = cin_q;
        REQ_READY = req_rdy_q;
        RSP_VALID = (state_q == S_RESP);
        RSP_RES   = rsp_res_q;
        RSP_FLAGS = rsp_flags_q;
    end

    // Counter is decremented at the issue edge too, so capture lands N edges after it.
    always_comb begin
        req_rdy_d   = (state_d == S_IDLE);
        opa_d       = accept ? REQ_OPA       : opa_q;
        opb_d       = accept ? REQ_OPB       : opb_q;
        cmd_d       = accept ? REQ_CMD       : cmd_q;
        mode_d      = accept ? REQ_MODE      : mode_q;
        cin_d       = accept ? REQ_CIN       : cin_q;
        inp_valid_d = accept ? REQ_INP_VALID : inp_valid_q;
        cnt_d       = cnt_q;
        if (accept) begin
            cnt_d = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
        end else if ((state_q == S_ISSUE) || ((state_q == S_WAIT) && (cnt_q != '0))) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        rsp_res_d   = capture ? RES : rsp_res_q;
        rsp_flags_d = capture ? {ERR, OFLOW, COUT, G, L, E} : rsp_flags_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            req_rdy_q   <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            inp_valid_q <= 2'b00;
            cnt_q       <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            req_rdy_q   <= req_rdy_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            cmd_q       <= cmd_d;
            mode_q      <= mode_d;
            cin_q       <= cin_d;
            inp_valid_q <= inp_valid_d;
            cnt_q       <= cnt_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0] issue_cnt_q, issue_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        err_cnt_d   = err_cnt_q;
        if ((state_q == S_ISSUE) && (issue_cnt_q != 16'hFFFF)) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end
        if (capture && ERR && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            issue_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign ISSUE_CNT = issue_cnt_q;
    assign ERR_CNT   = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU whose outputs are only correct at the intended sample edge,
// directed reset/latency/backpressure cases followed by randomized ops.
module tb_alu_op_sequencer;

    localparam int W       = 8;
    localparam int CW      = 4;
    localparam int LAT     = 1;
    localparam int MUL_LAT = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID, REQ_READY;
    logic [W-1:0]  REQ_OPA, REQ_OPB;
    logic [CW-1:0] REQ_CMD;
    logic          REQ_MODE, REQ_CIN;
    logic [1:0]    REQ_INP_VALID;
    logic          RSP_VALID, RSP_READY;
    logic [2*W-1:0] RSP_RES;
    logic [5:0]    RSP_FLAGS;
    logic [1:0]    INP_VALID;
    logic          MODE, CE, CIN;
    logic [CW-1:0] CMD;
    logic [W-1:0]  OPA, OPB;
    logic [2*W-1:0] RES;
    logic          ERR, OFLOW, COUT, G, L, E;
`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0]   issue_cnt, err_cnt;
`endif

    alu_op_sequencer #(.WIDTH(W), .CMD_W(CW), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CMD(REQ_CMD),
        .REQ_MODE(REQ_MODE), .REQ_CIN(REQ_CIN), .REQ_INP_VALID(REQ_INP_VALID),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS),
        .INP_VALID(INP_VALID), .MODE(MODE), .CMD(CMD), .CE(CE),
        .OPA(OPA), .OPB(OPB), .CIN(CIN),
        .RES(RES), .ERR(ERR), .OFLOW(OFLOW), .COUT(COUT), .G(G), .L(L), .E(E)
`ifdef ALU_OP_SEQUENCER_STATS_EN
        , .ISSUE_CNT(issue_cnt), .ERR_CNT(err_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_issue = 0;
    int exp_err   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference ALU behaviour: {RES[15:0], ERR, OFLOW, COUT, G, L, E}
    function automatic logic [21:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] cmd, input logic mode,
                                            input logic cin, input logic [1:0] iv);
        logic [15:0] r;
        logic err, ofl, co, g, l, e;
        r = '0; ofl = 0; g = 0; l = 0; e = 0;
        err = (iv == 2'b00);
        if (mode) begin
            case (cmd)
                4'd0:  r = 16'(a) + 16'(b);
                4'd1:  begin r = 16'(a) - 16'(b); ofl = (a < b); end
                4'd2:  r = 16'(a) + 16'(b) + 16'(cin);
                4'd8:  begin g = (a > b); l = (a < b); e = (a == b); end
                4'd9:  r = 16'(a) * 16'(b);
                4'd10: r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                default: r = 16'(a) + 16'(cmd);
            endcase
        end else begin
            case (cmd)
                4'd0:    r = {8'h00, a & b};
                4'd1:    r = {8'h00, a | b};
                4'd2:    r = {8'h00, a ^ b};
                default: r = {8'h00, ~(a ^ b)};
            endcase
        end
        co = mode ? r[8] : 1'b0;
        return {r, err, ofl, co, g, l, e};
    endfunction

    function automatic int lat_of(input logic mode, input logic [3:0] cmd);
        return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : LAT;
    endfunction

    // Behavioural ALU: outputs are only correct during the cycle before the intended sample edge.
    int          k = 1000;
    int          alu_lat = 1;
    int          ce_cnt = 0;
    logic [21:0] alu_ok = '0;

    always @(posedge CLK) begin
        if (CE) begin
            k       <= 0;
            alu_ok  <= ref_alu(OPA, OPB, CMD, MODE, CIN, INP_VALID);
            alu_lat <= lat_of(MODE, CMD);
            ce_cnt  <= ce_cnt + 1;
        end else if (k < 1000) begin
            k <= k + 1;
        end
    end

    logic good_win;
    assign good_win = (k == alu_lat - 1);
    assign RES = good_win ? alu_ok[21:6] : (alu_ok[21:6] ^ 16'hA5C3 ^ 16'(k));
    assign {ERR, OFLOW, COUT, G, L, E} = good_win ? alu_ok[5:0] : ~alu_ok[5:0];

    // Must be called at a negedge; returns at a negedge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd,
                         input logic mode, input logic cin, input logic [1:0] iv, input int hold);
        logic [21:0] exp;
        int n, ce_before, e;
        bit ok;
        exp       = ref_alu(a, b, cmd, mode, cin, iv);
        n         = lat_of(mode, cmd);
        ce_before = ce_cnt;
        REQ_OPA = a; REQ_OPB = b; REQ_CMD = cmd; REQ_MODE = mode; REQ_CIN = cin;
        REQ_INP_VALID = iv; REQ_VALID = 1'b1;
        RSP_READY = (hold == 0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (REQ_READY) begin ok = 1; break; end
            @(negedge CLK);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            REQ_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        REQ_OPA = $urandom; REQ_OPB = $urandom; REQ_CMD = $urandom; REQ_CIN = $urandom;
        REQ_MODE = $urandom; REQ_INP_VALID = $urandom;
        @(negedge CLK);
        check("ce_issue", CE, 1);
        check("issue_opa", OPA, a);
        check("issue_opb", OPB, b);
        check("issue_cmd", CMD, cmd);
        check("issue_mode", MODE, mode);
        check("issue_cin", CIN, cin);
        check("issue_inp_valid", INP_VALID, iv);
        e = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            e++;
            if (CE) check("ce_extra_pulse", CE, 0);
            if (RSP_VALID) break;
        end
        check("rsp_latency", e, n);
        check("rsp_res", RSP_RES, exp[21:6]);
        check("rsp_flags", RSP_FLAGS, exp[5:0]);
        check("req_rdy_in_resp", REQ_READY, 0);
        for (int i = 0; i < hold; i++) begin
            REQ_VALID = 1'b1;
            @(negedge CLK);
            check("bp_valid", RSP_VALID, 1);
            check("bp_res", RSP_RES, exp[21:6]);
            check("bp_flags", RSP_FLAGS, exp[5:0]);
            check("bp_req_rdy", REQ_READY, 0);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        check("rsp_drop", RSP_VALID, 0);
        check("res_keep", RSP_RES, exp[21:6]);
        check("ce_count", ce_cnt - ce_before, 1);
        exp_issue++;
        if (iv == 2'b00) exp_err++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        RST = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
        REQ_OPA = '0; REQ_OPB = '0; REQ_CMD = '0; REQ_MODE = 1'b0; REQ_CIN = 1'b0; REQ_INP_VALID = '0;
        repeat (3) @(negedge CLK);
        check("rst_req_ready", REQ_READY, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_res", RSP_RES, 0);
        check("rst_rsp_flags", RSP_FLAGS, 0);
        check("rst_ce", CE, 0);
        check("rst_alu_out", {INP_VALID, MODE, CMD, OPA, OPB, CIN}, 0);
        RST = 1'b1;
        #1;
        check("ready_before_edge", REQ_READY, 0);
        @(negedge CLK);
        check("ready_after_edge", REQ_READY, 1);
        repeat (3) @(negedge CLK);
        check("idle_no_ce", ce_cnt, 0);

        do_op(8'h0F, 8'h01, 4'd0, 1'b1, 1'b0, 2'b11, 0);
        do_op(8'h03, 8'h04, 4'd9, 1'b1, 1'b0, 2'b11, 0);
        do_op(8'h81, 8'h7F, 4'd1, 1'b1, 1'b0, 2'b11, 5);
        do_op(8'h22, 8'h11, 4'd2, 1'b1, 1'b1, 2'b00, 0);
        do_op(8'hFE, 8'h02, 4'd10, 1'b1, 1'b0, 2'b01, 0);
        do_op(8'h5A, 8'h5A, 4'd8, 1'b1, 1'b0, 2'b10, 2);
        do_op(8'hC3, 8'h3C, 4'd9, 1'b0, 1'b1, 2'b11, 0);

        // Abort a multiply while in WAIT
        REQ_OPA = 8'h05; REQ_OPB = 8'h06; REQ_CMD = 4'd9; REQ_MODE = 1'b1; REQ_CIN = 1'b0;
        REQ_INP_VALID = 2'b11; REQ_VALID = 1'b1; RSP_READY = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (REQ_READY) break;
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
        check("abort_ce_issue", CE, 1);
        @(posedge CLK);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        check("abort_ce", CE, 0);
        check("abort_rsp_valid", RSP_VALID, 0);
        check("abort_rsp_res", RSP_RES, 0);
        check("abort_req_ready", REQ_READY, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (RSP_VALID) seen = 1;
        end
        check("abort_no_rsp", seen, 0);
        exp_issue = 0;
        exp_err   = 0;
        do_op(8'h07, 8'h09, 4'd9, 1'b1, 1'b0, 2'b11, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  (i == 23) ? 0 : int'($urandom_range(0, 3)));
        end
        do_op(8'h10, 8'h20, 4'd0, 1'b1, 1'b0, 2'b00, 0);

`ifdef ALU_OP_SEQUENCER_STATS_EN
        check("stat_issue_cnt", issue_cnt, exp_issue);
        check("stat_err_cnt", err_cnt, exp_err);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
